// File: rtl/mmm_nlp_arb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmm_nlp_arb_if: client, multiplier and result bundle for mmm_nlp_arb. Rev 1.0
// ---------------------------------------------------------------------------
interface mmm_nlp_arb_if #(
  parameter int IDW = 90,
  parameter int ODW = 181,
  parameter int CW  = 16
);
  logic           i_req0_vld;
  logic [IDW-1:0] i_req0_a;
  logic [IDW-1:0] i_req0_b;
  logic           o_req0_rdy;
  logic           i_req1_vld;
  logic [IDW-1:0] i_req1_a;
  logic [IDW-1:0] i_req1_b;
  logic           o_req1_rdy;
  logic [IDW-1:0] o_mul_a;
  logic [IDW-1:0] o_mul_b;
  logic [ODW-1:0] i_mul_res;
  logic           o_res_vld;
  logic           o_res_id;
  logic [ODW-1:0] o_res;
  logic           o_busy;
  logic [CW-1:0]  o_cnt0;
  logic [CW-1:0]  o_cnt1;

  modport slave (
    input  i_req0_vld, i_req0_a, i_req0_b, i_req1_vld, i_req1_a, i_req1_b, i_mul_res,
    output o_req0_rdy, o_req1_rdy, o_mul_a, o_mul_b, o_res_vld, o_res_id, o_res,
           o_busy, o_cnt0, o_cnt1
  );

  modport master (
    output i_req0_vld, i_req0_a, i_req0_b, i_req1_vld, i_req1_a, i_req1_b, i_mul_res,
    input  o_req0_rdy, o_req1_rdy, o_mul_a, o_mul_b, o_res_vld, o_res_id, o_res,
           o_busy, o_cnt0, o_cnt1
  );
endinterface
`default_nettype wire

// File: rtl/mmm_nlp_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mmm_nlp_arb: round-robin sharing of one pipelined multiplier by two clients. Rev 1.0
// ---------------------------------------------------------------------------
module mmm_nlp_arb #(
  parameter int IDW = 90,
  parameter int ODW = 181,
  parameter int LAT = 4,
  parameter int CW  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  mmm_nlp_arb_if.slave  bus
);

  logic           gnt0;
  logic           gnt1;
  logic           ptr_q, ptr_d;
  logic [IDW-1:0] mul_a_q, mul_a_d;
  logic [IDW-1:0] mul_b_q, mul_b_d;
  // Stage k holds the op issued k edges ago; the product is captured one edge
  // after it appears on i_mul_res, hence LAT+1 stages.
  logic [LAT:0]   trk_vld_q, trk_vld_d;
  logic [LAT:0]   trk_id_q, trk_id_d;
  logic           res_vld_q, res_vld_d;
  logic           res_id_q, res_id_d;
  logic [ODW-1:0] res_q, res_d;
  logic [CW-1:0]  cnt0_q, cnt0_d;
  logic [CW-1:0]  cnt1_q, cnt1_d;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (bus.i_req0_vld && bus.i_req1_vld) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = bus.i_req0_vld;
        gnt1 = bus.i_req1_vld;
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    mul_a_d   = '0;
    mul_b_d   = '0;
    trk_vld_d = {trk_vld_q[LAT-1:0], gnt0 | gnt1};
    trk_id_d  = {trk_id_q[LAT-1:0], gnt1};
    res_vld_d = trk_vld_q[LAT];
    res_id_d  = res_id_q;
    res_d     = res_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;

    if (gnt0) begin
      ptr_d   = 1'b1;
      mul_a_d = bus.i_req0_a;
      mul_b_d = bus.i_req0_b;
    end else if (gnt1) begin
      ptr_d   = 1'b0;
      mul_a_d = bus.i_req1_a;
      mul_b_d = bus.i_req1_b;
    end

    if (trk_vld_q[LAT]) begin
      res_id_d = trk_id_q[LAT];
      res_d    = bus.i_mul_res;
      if (trk_id_q[LAT]) cnt1_d = cnt1_q + CW'(1);
      else               cnt0_d = cnt0_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q     <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      trk_vld_q <= '0;
      trk_id_q  <= '0;
      res_vld_q <= 1'b0;
      res_id_q  <= 1'b0;
      res_q     <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      ptr_q     <= ptr_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      trk_vld_q <= trk_vld_d;
      trk_id_q  <= trk_id_d;
      res_vld_q <= res_vld_d;
      res_id_q  <= res_id_d;
      res_q     <= res_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign bus.o_req0_rdy = gnt0;
  assign bus.o_req1_rdy = gnt1;
  assign bus.o_mul_a    = mul_a_q;
  assign bus.o_mul_b    = mul_b_q;
  assign bus.o_res_vld  = res_vld_q;
  assign bus.o_res_id   = res_id_q;
  assign bus.o_res      = res_q;
  assign bus.o_busy     = (|trk_vld_q) | res_vld_q;
  assign bus.o_cnt0     = cnt0_q;
  assign bus.o_cnt1     = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_mmm_nlp_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mmm_nlp_arb: randomized and directed bench for mmm_nlp_arb with a queue model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mmm_nlp_arb;
  localparam int IDW = 90;
  localparam int ODW = 181;
  localparam int LAT = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  mmm_nlp_arb_if #(.IDW(IDW), .ODW(ODW), .CW(CW)) bus ();

  mmm_nlp_arb #(.IDW(IDW), .ODW(ODW), .LAT(LAT), .CW(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: product of the operands presented LAT edges earlier.
  logic [ODW-1:0] mul_pipe [LAT];
  always @(posedge clk) begin
    mul_pipe[0] <= ODW'(bus.o_mul_a) * ODW'(bus.o_mul_b);
    for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign bus.i_mul_res = mul_pipe[LAT-1];

  task automatic chk(input string nm, input logic [ODW-1:0] act, input logic [ODW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted op is queued with the cycle its result is due.
  typedef struct {
    logic           id;
    logic [ODW-1:0] prod;
    int             due;
  } op_t;

  op_t            q[$];
  logic           m_ptr = 1'b0;
  logic [CW-1:0]  m_cnt[2];
  logic [IDW-1:0] m_mul_a = '0;
  logic [IDW-1:0] m_mul_b = '0;
  logic [ODW-1:0] m_res = '0;
  logic           m_id = 1'b0;

  always @(negedge clk) begin
    logic e_vld, e_busy, g0, g1;
    if (rst) begin
      q.delete();
      m_ptr = 1'b0; m_cnt[0] = '0; m_cnt[1] = '0;
      m_mul_a = '0; m_mul_b = '0; m_res = '0; m_id = 1'b0;
      chk("rst_rdy0", ODW'(bus.o_req0_rdy), '0);
      chk("rst_rdy1", ODW'(bus.o_req1_rdy), '0);
      chk("rst_res_vld", ODW'(bus.o_res_vld), '0);
      chk("rst_res", bus.o_res, '0);
      chk("rst_busy", ODW'(bus.o_busy), '0);
      chk("rst_cnt0", ODW'(bus.o_cnt0), '0);
    end else begin
      e_busy = (q.size() != 0);
      e_vld  = 1'b0;
      if (q.size() != 0 && q[0].due == cyc) begin
        e_vld = 1'b1;
        m_res = q[0].prod;
        m_id  = q[0].id;
        m_cnt[q[0].id] = m_cnt[q[0].id] + 1'b1;
        void'(q.pop_front());
      end
      chk("mul_a", ODW'(bus.o_mul_a), ODW'(m_mul_a));
      chk("mul_b", ODW'(bus.o_mul_b), ODW'(m_mul_b));
      chk("res_vld", ODW'(bus.o_res_vld), ODW'(e_vld));
      chk("res", bus.o_res, m_res);
      chk("res_id", ODW'(bus.o_res_id), ODW'(m_id));
      chk("cnt0", ODW'(bus.o_cnt0), ODW'(m_cnt[0]));
      chk("cnt1", ODW'(bus.o_cnt1), ODW'(m_cnt[1]));
      chk("busy", ODW'(bus.o_busy), ODW'(e_busy));
      // Grant rules: single requester wins; contention resolved by pointer.
      if (bus.i_req0_vld && bus.i_req1_vld) begin
        g0 = (m_ptr == 1'b0); g1 = (m_ptr == 1'b1);
      end else begin
        g0 = bus.i_req0_vld; g1 = bus.i_req1_vld;
      end
      chk("rdy0", ODW'(bus.o_req0_rdy), ODW'(g0));
      chk("rdy1", ODW'(bus.o_req1_rdy), ODW'(g1));
      m_mul_a = '0; m_mul_b = '0;
      if (g0) begin
        m_mul_a = bus.i_req0_a; m_mul_b = bus.i_req0_b; m_ptr = 1'b1;
        q.push_back('{id: 1'b0, prod: ODW'(bus.i_req0_a) * ODW'(bus.i_req0_b), due: cyc + LAT + 2});
      end else if (g1) begin
        m_mul_a = bus.i_req1_a; m_mul_b = bus.i_req1_b; m_ptr = 1'b0;
        q.push_back('{id: 1'b1, prod: ODW'(bus.i_req1_a) * ODW'(bus.i_req1_b), due: cyc + LAT + 2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IDW-1:0] rnd_op();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) t = '1;
    else if ($urandom_range(0, 7) == 0) t = '0;
    return t[IDW-1:0];
  endfunction

  localparam logic [ODW-1:0] MAXSQ = (ODW'(1) << 180) - (ODW'(1) << 91) + ODW'(1);

  initial begin
    int ops;
    int guard;
    bus.i_req0_vld = 1'b0; bus.i_req0_a = '0; bus.i_req0_b = '0;
    bus.i_req1_vld = 1'b0; bus.i_req1_a = '0; bus.i_req1_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single op from requester 0
    bus.i_req0_vld = 1'b1; bus.i_req0_a = IDW'(3); bus.i_req0_b = IDW'(5);
    #1 chk("t1_rdy0", ODW'(bus.o_req0_rdy), ODW'(1));
    tick();
    chk("t1_mul_a", ODW'(bus.o_mul_a), ODW'(3));
    chk("t1_mul_b", ODW'(bus.o_mul_b), ODW'(5));
    bus.i_req0_vld = 1'b0;
    repeat (LAT) tick();
    chk("t1_early", ODW'(bus.o_res_vld), ODW'(0));
    tick();
    chk("t1_vld", ODW'(bus.o_res_vld), ODW'(1));
    chk("t1_id", ODW'(bus.o_res_id), ODW'(0));
    chk("t1_res", bus.o_res, ODW'(15));
    chk("t1_cnt0", ODW'(bus.o_cnt0), ODW'(1));

    // Alternation under constant contention, starting from ptr=0
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 8; i++) begin
      bus.i_req0_vld = 1'b1; bus.i_req0_a = IDW'(i + 1); bus.i_req0_b = IDW'(7);
      bus.i_req1_vld = 1'b1; bus.i_req1_a = IDW'(i + 2); bus.i_req1_b = IDW'(9);
      #1;
      chk("t2_rdy0", ODW'(bus.o_req0_rdy), ODW'(i % 2 == 0));
      chk("t2_rdy1", ODW'(bus.o_req1_rdy), ODW'(i % 2 == 1));
      tick();
    end
    bus.i_req0_vld = 1'b0; bus.i_req1_vld = 1'b0;
    repeat (LAT + 3) tick();
    chk("t2_cnt0", ODW'(bus.o_cnt0), ODW'(4));
    chk("t2_cnt1", ODW'(bus.o_cnt1), ODW'(4));

    // Full-width product followed back-to-back by a zero product
    bus.i_req1_vld = 1'b1; bus.i_req1_a = '1; bus.i_req1_b = '1;
    tick();
    bus.i_req1_vld = 1'b0;
    bus.i_req0_vld = 1'b1; bus.i_req0_a = IDW'(1); bus.i_req0_b = '0;
    tick();
    bus.i_req0_vld = 1'b0;
    repeat (LAT) tick();
    chk("t3_vld1", ODW'(bus.o_res_vld), ODW'(1));
    chk("t3_id1", ODW'(bus.o_res_id), ODW'(1));
    chk("t3_max", bus.o_res, MAXSQ);
    tick();
    chk("t3_vld0", ODW'(bus.o_res_vld), ODW'(1));
    chk("t3_id0", ODW'(bus.o_res_id), ODW'(0));
    chk("t3_zero", bus.o_res, '0);
    repeat (3) tick();

    // Reset with three ops in flight
    bus.i_req0_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.i_req0_a = rnd_op(); bus.i_req0_b = rnd_op();
      tick();
    end
    rst = 1'b1;
    #1;
    chk("t4_rdy0", ODW'(bus.o_req0_rdy), '0);
    chk("t4_mul_a", ODW'(bus.o_mul_a), '0);
    chk("t4_res_vld", ODW'(bus.o_res_vld), '0);
    chk("t4_busy", ODW'(bus.o_busy), '0);
    tick();
    rst = 1'b0; bus.i_req0_vld = 1'b0;
    repeat (LAT + 3) begin
      tick();
      chk("t4_no_res", ODW'(bus.o_res_vld), '0);
      chk("t4_idle", ODW'(bus.o_busy), '0);
    end

    // First grant after release uses ptr=0; then drive cnt0 to wrap
    bus.i_req0_vld = 1'b1; bus.i_req0_a = rnd_op(); bus.i_req0_b = rnd_op();
    bus.i_req1_vld = 1'b1; bus.i_req1_a = rnd_op(); bus.i_req1_b = rnd_op();
    #1;
    chk("t5_ptr0_rdy0", ODW'(bus.o_req0_rdy), ODW'(1));
    chk("t5_ptr0_rdy1", ODW'(bus.o_req1_rdy), ODW'(0));
    tick();
    bus.i_req1_vld = 1'b0;
    repeat (65534) tick();
    bus.i_req0_vld = 1'b0;
    repeat (LAT + 3) tick();
    chk("t5_full", ODW'(bus.o_cnt0), ODW'(16'hFFFF));
    bus.i_req0_vld = 1'b1;
    tick();
    bus.i_req0_vld = 1'b0;
    repeat (LAT + 3) tick();
    chk("t5_wrap", ODW'(bus.o_cnt0), ODW'(0));
    chk("t5_cnt1", ODW'(bus.o_cnt1), ODW'(0));

    // Random traffic on both ports
    ops = 0;
    guard = 0;
    while (ops < 10000 && guard < 30000) begin
      bus.i_req0_vld = ($urandom_range(0, 3) != 0);
      bus.i_req1_vld = ($urandom_range(0, 3) != 0);
      bus.i_req0_a = rnd_op(); bus.i_req0_b = rnd_op();
      bus.i_req1_a = rnd_op(); bus.i_req1_b = rnd_op();
      #1;
      if ((bus.i_req0_vld && bus.o_req0_rdy) || (bus.i_req1_vld && bus.o_req1_rdy)) ops++;
      tick();
      guard++;
    end
    chk("t6_op_budget", ODW'(ops >= 10000), ODW'(1));
    bus.i_req0_vld = 1'b0; bus.i_req1_vld = 1'b0;
    repeat (LAT + 4) tick();
    chk("t6_drained", ODW'(bus.o_busy), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
